// File: rtl/mgt01_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per enabled cycle, full 2*XLEN-bit product.
// Per-operand signedness flags cover MUL/MULH/MULHSU/MULHU and the FP mantissa path.
module mgt01_booth_multiplier #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clk_en_i,
  input  logic                start_i,
  input  logic [XLEN-1:0]     multiplicand_i,
  input  logic [XLEN-1:0]     multiplier_i,
  input  logic                signed_a_i,
  input  logic                signed_b_i,
  output logic [2*XLEN-1:0]   product_o,
  output logic                busy_o,
  output logic                valid_o
);

  localparam int unsigned QW = XLEN + 1;
  localparam int unsigned AW = XLEN + 2;
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULTIPLY = 2'd1,
    ST_VALID    = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [QW-1:0]   a_q;
  logic [AW-1:0]   acc_q;
  logic [QW-1:0]   q_q;
  logic            qm1_q;

  logic [QW-1:0]   a_ext_in;
  logic [QW-1:0]   b_ext_in;
  logic [AW-1:0]   a_wide;
  logic [AW-1:0]   acc_sum;
  logic [AW-1:0]   acc_nxt;
  logic [QW-1:0]   q_nxt;
  logic            qm1_nxt;
  logic            last_step;

  // Operand extension to XLEN+1 bits according to the signedness flags.
  assign a_ext_in = signed_a_i ? {multiplicand_i[XLEN-1], multiplicand_i} : {1'b0, multiplicand_i};
  assign b_ext_in = signed_b_i ? {multiplier_i[XLEN-1], multiplier_i} : {1'b0, multiplier_i};
  assign a_wide   = {a_q[QW-1], a_q};
  assign last_step = (cnt_q == CW'(XLEN));

  // One Booth step: conditional add/sub of A, then arithmetic shift of {acc,Q,q_-1}.
  always_comb begin
    acc_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + a_wide;
      2'b10:   acc_sum = acc_q - a_wide;
      default: acc_sum = acc_q;
    endcase
    acc_nxt = {acc_sum[AW-1], acc_sum[AW-1:1]};
    q_nxt   = {acc_sum[0], q_q[QW-1:1]};
    qm1_nxt = q_q[0];
  end

  // Control FSM and datapath registers; clk_en_i low freezes everything.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      product_o <= '0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
    end else if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_q     <= a_ext_in;
            acc_q   <= '0;
            q_q     <= b_ext_in;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= ST_MULTIPLY;
          end
        end
        ST_MULTIPLY: begin
          acc_q <= acc_nxt;
          q_q   <= q_nxt;
          qm1_q <= qm1_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            // Low 2*XLEN bits of the exact 2*(XLEN+1)-bit result.
            product_o <= PW'({acc_nxt[XLEN-2:0], q_nxt});
            valid_o   <= 1'b1;
            state_q   <= ST_VALID;
          end
        end
        ST_VALID: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
